// File: rtl/alu_shift_seq.sv
// Microsequencer for the CB-prefix shift/rotate group: steps the ALU shifter
// through LOAD/RESULT cycle pairs and returns the 8-bit result plus Z/C flags.
module alu_shift_seq #(
    parameter int SWAP_PASSES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opc,
    input  logic [7:0] operand,
    input  logic       cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       flag_z,
    output logic       flag_c,
    output logic [7:0] alu_op,
    output logic       alu_si,
    output logic       alu_sh,
    output logic [1:0] alu_oe,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_l,
    output logic       alu_h,
    input  logic       shift_dbh,
    input  logic [7:0] alu_result
);

    localparam logic       L_SH    = 1'b0;
    localparam logic       R_SH    = 1'b1;
    localparam logic [1:0] SH_OE   = 2'b01;
    localparam logic [1:0] RES_OE  = 2'b10;
    localparam logic       BUS_LD  = 1'b1;
    localparam logic       NO_LD   = 1'b0;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam int         CW      = (SWAP_PASSES < 2) ? 1 : $clog2(SWAP_PASSES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RES, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      opc_q;
    logic [7:0]      work;
    logic            cin_q;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            dir;
    logic            si;
    logic            last_pass;

    assign last_pass = (cnt == CW'(1));

    // Direction and shift-in bit; SWAP is a plain left rotate repeated.
    always_comb begin
        dir = L_SH;
        si  = 1'b0;
        case (opc_q)
            3'd0: begin dir = L_SH; si = work[7]; end
            3'd1: begin dir = R_SH; si = work[0]; end
            3'd2: begin dir = L_SH; si = cin_q;   end
            3'd3: begin dir = R_SH; si = cin_q;   end
            3'd4: begin dir = L_SH; si = 1'b0;    end
            3'd5: begin dir = R_SH; si = work[7]; end
            3'd6: begin dir = L_SH; si = work[7]; end
            default: begin dir = R_SH; si = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_op    = 8'd0;
        alu_si    = 1'b0;
        alu_sh    = L_SH;
        alu_oe    = 2'b00;
        alu_la    = NO_LD;
        alu_lb    = NO_LD;
        alu_l     = 1'b0;
        alu_h     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                busy      = 1'b1;
                alu_op    = work;
                alu_si    = si;
                alu_sh    = dir;
                alu_oe    = SH_OE;
                alu_la    = BUS_LD;
                alu_lb    = BUS_LD;
                alu_l     = 1'b1;
                state_nxt = S_RES;
            end
            S_RES: begin
                busy      = 1'b1;
                alu_sh    = dir;
                alu_oe    = RES_OE;
                alu_h     = 1'b1;
                state_nxt = last_pass ? S_DONE : S_LOAD;
            end
            default: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Result/flags are committed on the final RESULT edge so they are
    // already valid while done is high, and held until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            opc_q  <= 3'd0;
            work   <= 8'd0;
            cin_q  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= 8'd0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    opc_q <= opc;
                    work  <= operand;
                    cin_q <= cin;
                    cnt   <= (opc == OP_SWAP) ? CW'(SWAP_PASSES) : CW'(1);
                end
                S_LOAD: carry <= shift_dbh;
                S_RES: begin
                    work <= alu_result;
                    cnt  <= cnt - CW'(1);
                    if (last_pass) begin
                        result <= alu_result;
                        flag_z <= (alu_result == 8'd0);
                        flag_c <= (opc_q == OP_SWAP) ? 1'b0 : carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Randomized and directed bench for alu_shift_seq with a behavioural ALU
// responder and an opcode-level reference model.
module tb_alu_shift_seq;

    localparam int SWAP_P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opc;
    logic [7:0] operand;
    logic       cin;
    logic       busy, done, flag_z, flag_c;
    logic [7:0] result, alu_op;
    logic       alu_si, alu_sh, alu_la, alu_lb, alu_l, alu_h;
    logic [1:0] alu_oe;
    logic       shift_dbh;
    logic [7:0] alu_result;

    int n_vec = 0;
    int n_err = 0;

    alu_shift_seq #(.SWAP_PASSES(SWAP_P)) dut (
        .clk(clk), .reset(reset), .start(start), .opc(opc), .operand(operand),
        .cin(cin), .busy(busy), .done(done), .result(result), .flag_z(flag_z),
        .flag_c(flag_c), .alu_op(alu_op), .alu_si(alu_si), .alu_sh(alu_sh),
        .alu_oe(alu_oe), .alu_la(alu_la), .alu_lb(alu_lb), .alu_l(alu_l),
        .alu_h(alu_h), .shift_dbh(shift_dbh), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // ALU shifter responder: shifted-out bit during LOAD, latched shift result later.
    logic [7:0] a_q;
    logic       sh_q, si_q;
    always @(posedge clk) begin
        if (alu_la) begin
            a_q  <= alu_op;
            sh_q <= alu_sh;
            si_q <= alu_si;
        end
    end
    assign shift_dbh  = alu_sh ? alu_op[0] : alu_op[7];
    assign alu_result = sh_q ? {si_q, a_q[7:1]} : {a_q[6:0], si_q};

    // Reference: {carry, zero, result} from instruction semantics.
    function automatic logic [9:0] ref_op(input logic [2:0] o, input logic [7:0] v, input logic ci);
        logic [7:0] r;
        logic       c;
        case (o)
            3'd0: begin r = {v[6:0], v[7]};  c = v[7]; end
            3'd1: begin r = {v[0], v[7:1]};  c = v[0]; end
            3'd2: begin r = {v[6:0], ci};    c = v[7]; end
            3'd3: begin r = {ci, v[7:1]};    c = v[0]; end
            3'd4: begin r = v << 1;          c = v[7]; end
            3'd5: begin r = {v[7], v[7:1]};  c = v[0]; end
            3'd6: begin r = {v[3:0], v[7:4]}; c = 1'b0; end
            default: begin r = v >> 1;       c = v[0]; end
        endcase
        return {c, (r == 8'd0), r};
    endfunction

    task automatic check_idle_outputs(input string name);
        logic [27:0] got;
        got = {busy, done, result, flag_z, flag_c, alu_op, alu_si, alu_sh, alu_oe,
               alu_la, alu_lb, alu_l, alu_h};
        n_vec++;
        if (got !== 28'd0) begin
            n_err++;
            $display("FAIL %s: got %h want 0000000", name, got);
        end
    endtask

    // Issue one op at the current negedge and follow it to done.
    task automatic run_op(input logic [2:0] o, input logic [7:0] v, input logic ci, input bit hold);
        logic [9:0]  exp;
        logic [7:0]  wv;
        logic        edir, esi;
        logic [15:0] gl, el;
        logic [6:0]  gr, er;
        int lat, ndone, nload, exp_lat, exp_loads;
        exp       = ref_op(o, v, ci);
        exp_loads = (o == 3'd6) ? SWAP_P : 1;
        exp_lat   = 2 * exp_loads + 1;
        opc = o; operand = v; cin = ci; start = 1'b1;
        wv = v; edir = 1'b0; lat = 0; ndone = 0; nload = 0;
        while (ndone == 0 && lat < 40) begin
            @(negedge clk);
            lat++;
            start   = (hold && lat < exp_lat) ? 1'b1 : 1'b0;
            opc     = 3'($urandom);
            operand = 8'($urandom);
            cin     = 1'($urandom);
            if (alu_l) begin
                case (o)
                    3'd0: begin edir = 1'b0; esi = wv[7]; end
                    3'd1: begin edir = 1'b1; esi = wv[0]; end
                    3'd2: begin edir = 1'b0; esi = ci;    end
                    3'd3: begin edir = 1'b1; esi = ci;    end
                    3'd4: begin edir = 1'b0; esi = 1'b0;  end
                    3'd5: begin edir = 1'b1; esi = wv[7]; end
                    3'd6: begin edir = 1'b0; esi = wv[7]; end
                    default: begin edir = 1'b1; esi = 1'b0; end
                endcase
                gl = {alu_op, alu_sh, alu_si, alu_oe, alu_la, alu_lb, alu_l, alu_h};
                el = {wv, edir, esi, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
                n_vec++;
                if (gl !== el) begin
                    n_err++;
                    $display("FAIL load_phase op%0d pass%0d: got %h want %h", o, nload, gl, el);
                end
                wv = {wv[6:0], wv[7]};
                nload++;
            end else if (alu_h) begin
                gr = {alu_oe, alu_la, alu_lb, alu_l, alu_h, alu_sh};
                er = {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, edir};
                n_vec++;
                if (gr !== er) begin
                    n_err++;
                    $display("FAIL res_phase op%0d: got %h want %h", o, gr, er);
                end
            end
            if (done) ndone++;
        end
        n_vec++;
        if (ndone != 1 || lat != exp_lat || nload != exp_loads) begin
            n_err++;
            $display("FAIL latency op%0d: got lat=%0d loads=%0d done=%0d want lat=%0d loads=%0d done=1",
                     o, lat, nload, ndone, exp_lat, exp_loads);
        end
        n_vec++;
        if ({flag_c, flag_z, result} !== exp || busy !== 1'b1) begin
            n_err++;
            $display("FAIL result op%0d in=%h cin=%0d: got c/z/res=%h busy=%0d want %h busy=1",
                     o, v, ci, {flag_c, flag_z, result}, busy, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; opc = 3'd0; operand = 8'd0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_no_start");
    endtask

    task automatic test_directed();
        run_op(3'd4, 8'h81, 1'b1, 1'b0); @(negedge clk);
        run_op(3'd3, 8'h01, 1'b0, 1'b0); @(negedge clk);
        run_op(3'd3, 8'h01, 1'b1, 1'b0); @(negedge clk);
        run_op(3'd5, 8'h80, 1'b0, 1'b0); @(negedge clk);
        run_op(3'd7, 8'h01, 1'b0, 1'b0); @(negedge clk);
        run_op(3'd6, 8'hA5, 1'b1, 1'b0); @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int extra;
        run_op(3'd0, 8'h80, 1'b0, 1'b1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL ignore_start: got %0d extra busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int spurious;
        opc = 3'd6; operand = 8'hA5; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_midop");
        reset = 1'b0;
        spurious = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        n_vec++;
        if (spurious != 0) begin
            n_err++;
            $display("FAIL reset_discard: got %0d busy/done cycles want 0", spurious);
        end
        run_op(3'd4, 8'h40, 1'b0, 1'b0); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 8'h80, 1'b0, 1'b0);
        opc = 3'd7; operand = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_gap: got busy/done=%b want 00", {busy, done});
        end
        run_op(3'd7, 8'h01, 1'b0, 1'b0); @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
